// File: rtl/onboarding_pkg.sv
// Shared definitions for the onboarding peripheral: register-bank addresses
// and the PWM fade sequencer state encoding.
package onboarding_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    FADE_IDLE  = 2'd0,
    FADE_WAIT  = 2'd1,
    FADE_WRITE = 2'd2,
    FADE_DONE  = 2'd3
  } fade_state_e;

endpackage

// File: rtl/fade_step_timer.sv
// Loadable down-counter that times the pause between fade steps.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load the counter with value (wins over counting)
//   value     - count to load
//   expire    - high while the counter holds 1 (last cycle of the interval)
module fade_step_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == WIDTH'(1));

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM duty-cycle fade sequencer. On start it walks the duty register from
// cur_duty to target in step-sized increments, one register-bank write per
// interval, saturating at the target.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   start, abort           - begin a ramp / cancel (abort wins)
//   target, step, interval - ramp parameters, sampled on accepted start
//   cur_duty               - present duty value, sampled on accepted start
//   wr_valid/ready/addr/data - write request handshake into the register bank
//   busy                   - high whenever not idle
//   done                   - one-cycle pulse on normal completion
module pwm_fade_ctrl
  import onboarding_pkg::*;
#(
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned INTERVAL_W = 16,
  parameter logic [6:0]  DUTY_ADDR  = ADDR_PWM_DUTY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DUTY_W-1:0]     target,
  input  logic [DUTY_W-1:0]     step,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic [DUTY_W-1:0]     cur_duty,
  output logic                  wr_valid,
  output logic [6:0]            wr_addr,
  output logic [DUTY_W-1:0]     wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done
);

  fade_state_e           state_q, state_d;
  logic [DUTY_W-1:0]     cur_q, cur_d;
  logic [DUTY_W-1:0]     tgt_q, tgt_d;
  logic [DUTY_W-1:0]     step_q, step_d;
  logic [DUTY_W-1:0]     data_q, data_d;
  logic [INTERVAL_W-1:0] n_q, n_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tmr_load;
  logic [INTERVAL_W-1:0] tmr_value;
  logic                  tmr_expire;

  logic [DUTY_W-1:0]     step_in;
  logic [INTERVAL_W-1:0] n_in;
  logic [DUTY_W:0]       sum;
  logic [DUTY_W:0]       diff;
  logic [DUTY_W-1:0]     next_duty;

  assign step_in = (step == '0)     ? DUTY_W'(1)     : step;
  assign n_in    = (interval == '0) ? INTERVAL_W'(1) : interval;

  // One extra bit keeps carry/borrow visible so the step clamps to the
  // target instead of wrapping past it.
  always_comb begin
    sum  = {1'b0, cur_q} + {1'b0, step_q};
    diff = {1'b0, cur_q} - {1'b0, step_q};
    if (tgt_q > cur_q) begin
      next_duty = (sum >= {1'b0, tgt_q}) ? tgt_q : sum[DUTY_W-1:0];
    end else begin
      next_duty = (diff[DUTY_W] || (diff[DUTY_W-1:0] <= tgt_q)) ? tgt_q : diff[DUTY_W-1:0];
    end
  end

  fade_step_timer #(
    .WIDTH (INTERVAL_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    data_d    = data_q;
    n_d       = n_q;
    tmr_load  = 1'b0;
    tmr_value = n_q;

    if (abort) begin
      state_d = FADE_IDLE;
      // A write accepted on the abort edge has landed in the bank.
      if (state_q == FADE_WRITE && wr_ready) begin
        cur_d = data_q;
      end
    end else begin
      case (state_q)
        FADE_IDLE: begin
          if (start) begin
            tgt_d  = target;
            step_d = step_in;
            n_d    = n_in;
            cur_d  = cur_duty;
            if (cur_duty == target) begin
              state_d = FADE_DONE;
            end else begin
              state_d   = FADE_WAIT;
              tmr_load  = 1'b1;
              tmr_value = n_in;
            end
          end
        end
        FADE_WAIT: begin
          if (tmr_expire) begin
            data_d  = next_duty;
            state_d = FADE_WRITE;
          end
        end
        FADE_WRITE: begin
          if (wr_ready) begin
            cur_d = data_q;
            if (data_q == tgt_q) begin
              state_d = FADE_DONE;
            end else begin
              state_d  = FADE_WAIT;
              tmr_load = 1'b1;
            end
          end
        end
        FADE_DONE: begin
          state_d = FADE_IDLE;
        end
        default: begin
          state_d = FADE_IDLE;
        end
      endcase
    end

    valid_d = (state_d == FADE_WRITE);
    busy_d  = (state_d != FADE_IDLE);
    done_d  = (state_d == FADE_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FADE_IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      data_q  <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      data_q  <= data_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_valid = valid_q;
  assign wr_addr  = DUTY_ADDR;
  assign wr_data  = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  target;
  logic [7:0]  step;
  logic [15:0] interval;
  logic [7:0]  cur_duty;
  logic        wr_valid;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(
    .DUTY_W     (8),
    .INTERVAL_W (16),
    .DUTY_ADDR  (7'h04)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .target   (target),
    .step     (step),
    .interval (interval),
    .cur_duty (cur_duty),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wdata_q[$];
  int waddr_q[$];
  int wcyc_q[$];
  int done_cyc_q[$];
  int last_busy_cyc = -1;

  // Each posedge is labelled with cyc; a value read at a negedge names the next posedge.
  always @(posedge clk) begin
    if (wr_valid && wr_ready) begin
      wdata_q.push_back(int'(wr_data));
      waddr_q.push_back(int'(wr_addr));
      wcyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
    if (busy) last_busy_cyc = cyc;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wdata_q.delete();
    waddr_q.delete();
    wcyc_q.delete();
    done_cyc_q.delete();
    last_busy_cyc = -1;
  endtask

  task automatic go(input logic [7:0] c, input logic [7:0] t, input logic [7:0] s,
                    input logic [15:0] iv, output int k);
    @(negedge clk);
    cur_duty = c; target = t; step = s; interval = iv; start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, " idle"}, busy, 1'b0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!wr_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, " valid"}, wr_valid, 1'b1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input int d, input int c);
    if (idx < wdata_q.size()) begin
      chk({tag, " data"}, wdata_q[idx], d);
      chk({tag, " addr"}, waddr_q[idx], 32'h04);
      chk({tag, " cycle"}, wcyc_q[idx], c);
    end else begin
      chk({tag, " present"}, wdata_q.size(), idx + 1);
    end
  endtask

  task automatic chk_done(input string tag, input int c);
    chk({tag, " done count"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) chk({tag, " done cycle"}, done_cyc_q[0], c);
    chk({tag, " busy falls with done"}, last_busy_cyc, c);
  endtask

  initial begin
    int k;
    int h;
    bit stable;
    rst = 1'b1; start = 1'b0; abort = 1'b0; target = '0; step = '0;
    interval = '0; cur_duty = '0; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset wr_valid", wr_valid, 1'b0);
    chk("reset wr_data", wr_data, 8'h00);
    chk("reset wr_addr", wr_addr, 7'h04);
    rst = 1'b0;
    clear_logs();

    // Upward ramp 00->40 step 10, N=4
    go(8'h00, 8'h40, 8'h10, 16'd4, k);
    chk("up busy after start", busy, 1'b1);
    chk("up no early valid", wr_valid, 1'b0);
    wait_idle("up", 100);
    chk("up count", wdata_q.size(), 4);
    chk_wr("up w0", 0, 'h10, k + 5);
    chk_wr("up w1", 1, 'h20, k + 10);
    chk_wr("up w2", 2, 'h30, k + 15);
    chk_wr("up w3", 3, 'h40, k + 20);
    chk_done("up", k + 21);
    clear_logs();

    // Downward ramp with saturation FF->05 step 40, N=2
    go(8'hFF, 8'h05, 8'h40, 16'd2, k);
    wait_idle("down", 100);
    chk("down count", wdata_q.size(), 4);
    chk_wr("down w0", 0, 'hBF, k + 3);
    chk_wr("down w1", 1, 'h7F, k + 6);
    chk_wr("down w2", 2, 'h3F, k + 9);
    chk_wr("down w3", 3, 'h05, k + 12);
    chk_done("down", k + 13);
    clear_logs();

    // Backpressure on first write, N=3
    wr_ready = 1'b0;
    go(8'h00, 8'h20, 8'h10, 16'd3, k);
    wait_valid("bp", 20);
    stable = 1'b1;
    repeat (10) begin
      if (!(wr_valid === 1'b1 && wr_data === 8'h10)) stable = 1'b0;
      @(negedge clk);
    end
    chk("bp stable while stalled", stable, 1'b1);
    wr_ready = 1'b1;
    h = cyc;
    wait_idle("bp", 100);
    chk("bp count", wdata_q.size(), 2);
    chk_wr("bp w0", 0, 'h10, h);
    chk_wr("bp w1", 1, 'h20, h + 4);
    chk_done("bp", h + 5);
    clear_logs();

    // cur_duty == target
    go(8'h80, 8'h80, 8'h10, 16'd4, k);
    chk("eq done next cycle", done, 1'b1);
    wait_idle("eq", 20);
    chk("eq no writes", wdata_q.size(), 0);
    chk_done("eq", k + 1);
    clear_logs();

    // step=0, interval=0 treated as 1
    go(8'h00, 8'h03, 8'h00, 16'd0, k);
    wait_idle("zero", 100);
    chk("zero count", wdata_q.size(), 3);
    chk_wr("zero w0", 0, 'h01, k + 2);
    chk_wr("zero w1", 1, 'h02, k + 4);
    chk_wr("zero w2", 2, 'h03, k + 6);
    chk_done("zero", k + 7);
    clear_logs();

    // Abort during WAIT
    go(8'h00, 8'h40, 8'h10, 16'd8, k);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort wait busy", busy, 1'b0);
    chk("abort wait valid", wr_valid, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort wait no writes", wdata_q.size(), 0);
    chk("abort wait no done", done_cyc_q.size(), 0);
    clear_logs();

    // Abort during stalled WRITE
    wr_ready = 1'b0;
    go(8'h00, 8'h40, 8'h10, 16'd2, k);
    wait_valid("abort wr", 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort wr valid", wr_valid, 1'b0);
    chk("abort wr busy", busy, 1'b0);
    wr_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort wr no writes", wdata_q.size(), 0);
    chk("abort wr no done", done_cyc_q.size(), 0);
    clear_logs();

    // Start while busy is ignored
    go(8'h00, 8'h20, 8'h10, 16'd4, k);
    cur_duty = 8'h99; target = 8'hF0; step = 8'h01; interval = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy start", 100);
    chk("busy start count", wdata_q.size(), 2);
    chk_wr("busy start w0", 0, 'h10, k + 5);
    chk_wr("busy start w1", 1, 'h20, k + 10);
    chk_done("busy start", k + 11);
    clear_logs();

    // start and abort together
    @(negedge clk);
    cur_duty = 8'h00; target = 8'h40; step = 8'h10; interval = 16'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("start+abort no writes", wdata_q.size(), 0);
    chk("start+abort never busy", last_busy_cyc, -1);
    clear_logs();

    // Asynchronous reset mid-ramp, then a fresh ramp
    go(8'h00, 8'h40, 8'h10, 16'd2, k);
    wait_valid("rst", 20);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst valid", wr_valid, 1'b0);
    chk("async rst done", done, 1'b0);
    chk("async rst data", wr_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    go(8'h00, 8'h20, 8'h10, 16'd1, k);
    wait_idle("post rst", 50);
    chk("post rst count", wdata_q.size(), 2);
    chk_wr("post rst w0", 0, 'h10, k + 2);
    chk_wr("post rst w1", 1, 'h20, k + 4);
    chk_done("post rst", k + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Duty-cycle ramp sequencer for the onboarding PWM peripheral. On a start pulse it steps the PWM duty-cycle register from its current value to a target value in fixed increments at a programmable interval. Each step is issued as a write request into the register bank, which arbitrates these writes against SPI-originated writes through a valid/ready handshake. The block removes the need for the SPI host to issue every intermediate duty value during fades.

## Interface
Parameters:
- DUTY_W, 8, width of duty, target and step values
- INTERVAL_W, 16, width of the step-interval count
- DUTY_ADDR, 7'h04, register-bank address of the PWM duty-cycle register

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  single-cycle request to begin a ramp; ignored while busy=1
- abort  in  1  stops the ramp; has priority over start
- target  in  DUTY_W  final duty value; sampled on an accepted start
- step  in  DUTY_W  increment size; sampled on start; 0 is treated as 1
- interval  in  INTERVAL_W  wait cycles between steps; sampled on start; 0 is treated as 1
- cur_duty  in  DUTY_W  current duty-cycle register value from the bank; sampled on start
- wr_valid  out  1  write request to the register bank
- wr_addr  out  7  always DUTY_ADDR
- wr_data  out  DUTY_W  duty value to write
- wr_ready  in  1  the bank accepts the write on any edge where wr_valid=1 and wr_ready=1
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse on normal completion of a ramp

## Operation
- FSM states: IDLE, WAIT, WRITE, DONE.
- IDLE:
  - On start with abort=0: latch target, step, interval and cur_duty into the internal register cur.
  - If cur==target, go to DONE.
  - Otherwise go to WAIT and load timer=N, where N=max(interval,1).
- WAIT:
  - timer decrements by 1 each cycle.
  - When timer reaches 1, compute next and go to WRITE.
  - Upward ramp: next = min(cur+step, target).
  - Downward ramp: next = max(cur-step, target).
  - Arithmetic is DUTY_W+1 bits wide, so the result never wraps or overshoots the target.
- WRITE:
  - wr_valid=1 and wr_data=next, both held stable until the handshake completes.
  - On the handshake edge, cur<=next.
  - If next==target, go to DONE. Otherwise go to WAIT and reload timer=N.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- abort: from any state, go to IDLE on the next edge with wr_valid=0 and no done pulse. A write that handshakes on the same edge as abort counts as completed at the bank.
- start while busy=1 is ignored with no side effects.
- Reset values: FSM=IDLE, busy=0, done=0, wr_valid=0, wr_data=0, cur=0, timer=0. wr_addr is constant.
- Reset mid-ramp clears all outputs immediately (asynchronous). The duty register keeps the last value written.

## Timing
- All outputs are registered (wr_addr is a constant).
- An accepted start on edge E0 gives busy=1 after E0.
- WAIT lasts exactly N cycles. wr_valid rises N cycles after WAIT is entered.
- With wr_ready tied high, WRITE lasts 1 cycle, so consecutive writes are spaced N+1 cycles apart.
- done is asserted in the cycle after the final write handshakes. busy falls together with done.
- When cur==target at start, done is asserted in the cycle after start and no writes are issued.
- Number of writes = ceil(|target-cur_duty| / max(step,1)).
- When wr_ready is low, WRITE is extended. The timer is not reloaded until the handshake completes.

## Structure
- Shared package onboarding_pkg holds:
  - Register address constants: ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_PWM_DUTY=0x04.
  - The fade FSM state enum.
- One sub-module, fade_step_timer: a loadable down-counter (load, value, expire) used for the WAIT interval.
- Direction, saturating add/subtract and the FSM stay in pwm_fade_ctrl.

## Test plan
- Upward ramp: cur_duty=0x00, target=0x40, step=0x10, interval=4, wr_ready=1 -> writes 0x10, 0x20, 0x30, 0x40 at 5-cycle spacing, all to addr 0x04; one done pulse; busy falls together with done.
- Downward ramp with saturation: cur_duty=0xFF, target=0x05, step=0x40 -> writes 0xBF, 0x7F, 0x3F, 0x05; no underflow.
- Backpressure: wr_ready held low for 10 cycles during the first write -> wr_valid=1 and wr_data=0x10 stay stable throughout; the next write is spaced N+1 cycles after acceptance.
- Degenerate inputs:
  - cur_duty==target=0x80 -> done in the cycle after start, zero writes.
  - step=0, interval=0, 0x00->0x03 -> writes 0x01, 0x02, 0x03 at 2-cycle spacing.
- Abort and restart:
  - abort in WAIT -> IDLE, no further writes, no done.
  - abort during a stalled WRITE -> wr_valid falls next cycle.
  - start while busy -> ignored.
  - start and abort in the same cycle -> block stays IDLE.
- Asynchronous reset mid-ramp -> busy, wr_valid and done go low immediately with no clock edge; a new start after reset runs a normal ramp.
